// File: rtl/ex_mem_reg_pkg.sv
// Shared constants and stage-control encoding for the EX->MEM pipeline register.
package ex_mem_reg_pkg;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'b0;
  localparam int unsigned STALL_EX      = 3;
  localparam int unsigned STALL_MEM     = 4;

  // One-hot pipeline stage action.
  typedef enum logic [3:0] {
    ActClr    = 4'b1000,
    ActBubble = 4'b0100,
    ActHold   = 4'b0010,
    ActAdv    = 4'b0001
  } stage_act_e;

endpackage

// File: rtl/ex_mem_reg_pipe_stage_ctl.sv
// Decodes reset/flush/stall into a one-hot stage action; shared by all pipeline registers.
module ex_mem_reg_pipe_stage_ctl
  import ex_mem_reg_pkg::*;
#(
  parameter int unsigned STALL_W = 6,
  parameter int unsigned EX_IDX  = STALL_EX,
  parameter int unsigned MEM_IDX = STALL_MEM
) (
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  output stage_act_e         act,
  output logic               illegal
);

  logic ex_st;
  logic mem_st;
  logic unused_stall;

  assign ex_st        = stall[EX_IDX];
  assign mem_st       = stall[MEM_IDX];
  // Only the two stage bits matter; the rest are deliberately ignored.
  assign unused_stall = ^stall;

  // Priority decode: reset, flush, bubble, hold, advance.
  always_comb begin
    act     = ActHold;
    illegal = !ex_st && mem_st;
    if (rst == RST_ENABLE) begin
      act = ActClr;
    end else if (flush) begin
      act = ActClr;
    end else if (ex_st && !mem_st) begin
      act = ActBubble;
    end else if (!ex_st && !mem_st) begin
      act = ActAdv;
    end else begin
      // Both stalled, or the illegal later-stage-only stall: freeze.
      act = ActHold;
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with stall/flush, valid gating, multi-cycle carry-over and
// a saturating bubble counter.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned EX_IDX  = STALL_EX,
  parameter int unsigned MEM_IDX = STALL_MEM,
  parameter int unsigned PERF_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [RADDR_W-1:0]  ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic                mem_valid,
  output logic [RADDR_W-1:0]  mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic [PERF_W-1:0]   bubble_cnt
);

  stage_act_e act;
  logic       illegal;

  ex_mem_reg_pipe_stage_ctl #(
    .STALL_W (STALL_W),
    .EX_IDX  (EX_IDX),
    .MEM_IDX (MEM_IDX)
  ) u_ctl (
    .rst     (rst),
    .flush   (flush),
    .stall   (stall),
    .act     (act),
    .illegal (illegal)
  );

  // Stage contents and multi-cycle carry-over.
  always_ff @(posedge clk) begin
    unique case (act)
      ActClr, ActBubble: begin
        mem_valid <= 1'b0;
        mem_wd    <= RADDR_W'(NOP_REG_ADDR);
        mem_wreg  <= WRITE_DISABLE;
        mem_wdata <= DATA_W'(ZERO_WORD);
        mem_whilo <= WRITE_DISABLE;
        mem_hi    <= DATA_W'(ZERO_WORD);
        mem_lo    <= DATA_W'(ZERO_WORD);
        // A bubble keeps the madd/msub partial result alive for EX; a clear drops it.
        if (act == ActBubble) begin
          hilo_temp_o <= hilo_i;
          cnt_o       <= cnt_i;
        end else begin
          hilo_temp_o <= '0;
          cnt_o       <= '0;
        end
      end
      ActAdv: begin
        mem_valid   <= ex_valid;
        mem_wd      <= ex_wd;
        mem_wreg    <= ex_valid ? ex_wreg : WRITE_DISABLE;
        mem_wdata   <= ex_wdata;
        mem_whilo   <= ex_valid ? ex_whilo : WRITE_DISABLE;
        mem_hi      <= ex_hi;
        mem_lo      <= ex_lo;
        hilo_temp_o <= '0;
        cnt_o       <= '0;
      end
      default: begin
      end
    endcase
  end

  // Saturating bubble counter; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      bubble_cnt <= '0;
    end else if (act == ActBubble && bubble_cnt != {PERF_W{1'b1}}) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  illegal_stall_a: assert property (@(posedge clk) disable iff (rst) !illegal);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg (PERF_W=2 so saturation is reachable).
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst, flush, ex_valid, ex_wreg, ex_whilo;
  logic [5:0]  stall;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic        mem_valid, mem_wreg, mem_whilo;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o, bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem_reg #(.PERF_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_wd       (ex_wd),
    .ex_wreg     (ex_wreg),
    .ex_wdata    (ex_wdata),
    .ex_whilo    (ex_whilo),
    .ex_hi       (ex_hi),
    .ex_lo       (ex_lo),
    .hilo_i      (hilo_i),
    .cnt_i       (cnt_i),
    .mem_valid   (mem_valid),
    .mem_wd      (mem_wd),
    .mem_wreg    (mem_wreg),
    .mem_wdata   (mem_wdata),
    .mem_whilo   (mem_whilo),
    .mem_hi      (mem_hi),
    .mem_lo      (mem_lo),
    .hilo_temp_o (hilo_temp_o),
    .cnt_o       (cnt_o),
    .bubble_cnt  (bubble_cnt)
  );

  typedef struct {
    string       name;
    logic        rst, flush;
    logic [5:0]  stall;
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi, lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    // expected outputs after the edge
    logic        e_valid;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_hi, e_lo;
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt, e_bub;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [171:0] out_bus();
    return {mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
            hilo_temp_o, cnt_o, bubble_cnt};
  endfunction

  task automatic chk(input string name, input logic [171:0] got, input logic [171:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic chk_bub(input string name, input logic [1:0] exp);
    n_tests++;
    if (bubble_cnt !== exp) begin
      n_fail++;
      $display("FAIL %s: bubble_cnt got %0d want %0d", name, bubble_cnt, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; flush = v.flush; stall = v.stall; ex_valid = v.valid; ex_wd = v.wd;
    ex_wreg = v.wreg; ex_wdata = v.wdata; ex_whilo = v.whilo; ex_hi = v.hi; ex_lo = v.lo;
    hilo_i = v.hilo; cnt_i = v.cnt;
  endtask

  initial begin
    vec_t v;
    logic [63:0] h;

    // Row format: name, rst, flush, stall, inputs..., expected outputs...
    vecs.push_back('{"adv", 0, 0, 6'b000000, 1, 5'd5, 1, 32'hDEADBEEF, 0, 32'h0, 32'h0,
                     64'hAAAA, 2'd3,
                     1, 5'd5, 1, 32'hDEADBEEF, 0, 32'h0, 32'h0, 64'h0, 2'd0, 2'd0});
    vecs.push_back('{"bubble1", 0, 0, 6'b001111, 1, 5'd7, 1, 32'h1234, 1, 32'h1, 32'h2,
                     64'h1_0000_0002, 2'd1,
                     0, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'h1_0000_0002, 2'd1, 2'd1});
    vecs.push_back('{"bubble2", 0, 0, 6'b001111, 1, 5'd8, 1, 32'h5678, 0, 32'h0, 32'h0,
                     64'h3_0000_0004, 2'd2,
                     0, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'h3_0000_0004, 2'd2, 2'd2});
    vecs.push_back('{"adv_clr", 0, 0, 6'b000000, 1, 5'd9, 0, 32'h33, 1, 32'h11, 32'h22,
                     64'h9, 2'd1,
                     1, 5'd9, 0, 32'h33, 1, 32'h11, 32'h22, 64'h0, 2'd0, 2'd2});
    vecs.push_back('{"hold1", 0, 0, 6'b011111, 1, 5'd1, 1, 32'hFF, 0, 32'h5, 32'h6,
                     64'h5, 2'd3,
                     1, 5'd9, 0, 32'h33, 1, 32'h11, 32'h22, 64'h0, 2'd0, 2'd2});
    vecs.push_back('{"hold2", 0, 0, 6'b011111, 0, 5'd2, 0, 32'hEE, 1, 32'h7, 32'h8,
                     64'h6, 2'd2,
                     1, 5'd9, 0, 32'h33, 1, 32'h11, 32'h22, 64'h0, 2'd0, 2'd2});
    vecs.push_back('{"hold3", 0, 0, 6'b011000, 1, 5'd3, 1, 32'hDD, 1, 32'h9, 32'hA,
                     64'h7, 2'd1,
                     1, 5'd9, 0, 32'h33, 1, 32'h11, 32'h22, 64'h0, 2'd0, 2'd2});
    vecs.push_back('{"bubble3", 0, 0, 6'b001111, 1, 5'd4, 1, 32'hCC, 0, 32'h0, 32'h0,
                     64'h7, 2'd1,
                     0, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'h7, 2'd1, 2'd3});
    vecs.push_back('{"flush_stall", 0, 1, 6'b001111, 1, 5'd6, 1, 32'hBB, 1, 32'h1, 32'h1,
                     64'hF, 2'd3,
                     0, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'h0, 2'd0, 2'd3});
    vecs.push_back('{"bubble_sat", 0, 0, 6'b101000, 1, 5'd4, 1, 32'hCC, 0, 32'h0, 32'h0,
                     64'h8, 2'd2,
                     0, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'h8, 2'd2, 2'd3});
    vecs.push_back('{"adv_invalid", 0, 0, 6'b000000, 0, 5'd4, 1, 32'h55, 1, 32'h66, 32'h77,
                     64'h1, 2'd1,
                     0, 5'd4, 0, 32'h55, 0, 32'h66, 32'h77, 64'h0, 2'd0, 2'd3});
    vecs.push_back('{"flush_adv", 0, 1, 6'b000000, 1, 5'd12, 1, 32'h99, 1, 32'h1, 32'h2,
                     64'h3, 2'd1,
                     0, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'h0, 2'd0, 2'd3});
    vecs.push_back('{"adv_other_bits", 0, 0, 6'b100111, 1, 5'd31, 1, 32'hCAFEF00D, 1,
                     32'h12345678, 32'h9ABCDEF0, 64'h4, 2'd2,
                     1, 5'd31, 1, 32'hCAFEF00D, 1, 32'h12345678, 32'h9ABCDEF0, 64'h0, 2'd0,
                     2'd3});

    // Reset for two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1; flush = 1'($urandom); stall = 6'($urandom); ex_valid = 1'($urandom);
      ex_wd = 5'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom;
      ex_whilo = 1'($urandom); ex_hi = $urandom; ex_lo = $urandom;
      hilo_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
      @(posedge clk); #1;
      chk($sformatf("reset%0d", i), out_bus(), '0);
    end

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      drive(v);
      @(posedge clk); #1;
      chk(v.name, out_bus(), {v.e_valid, v.e_wd, v.e_wreg, v.e_wdata, v.e_whilo, v.e_hi,
                              v.e_lo, v.e_hilo, v.e_cnt, v.e_bub});
    end

    // Mid-run reset during a bubble request clears a saturated counter.
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; stall = 6'b001111; hilo_i = 64'hABCD; cnt_i = 2'd3;
    @(posedge clk); #1;
    chk("reset_mid", out_bus(), '0);

    // Five consecutive bubbles: counter 1,2,3,3,3; carry-over re-captured each cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst = 1'b0; stall = 6'b001111; h = 64'h100 + 64'(i); hilo_i = h; cnt_i = 2'(i);
      @(posedge clk); #1;
      chk_bub($sformatf("sat%0d", i), (i < 3) ? 2'(i + 1) : 2'd3);
      chk($sformatf("carry%0d", i), {108'h0, hilo_temp_o},
          {108'h0, h});
    end

    // First advance after bubbles drops the intermediate.
    @(negedge clk);
    stall = 6'b000000; ex_valid = 1'b1; ex_wd = 5'd2; ex_wreg = 1'b1; ex_wdata = 32'h42;
    ex_whilo = 1'b0; ex_hi = 32'h0; ex_lo = 32'h0; hilo_i = 64'hFFFF; cnt_i = 2'd3;
    @(posedge clk); #1;
    chk("adv_after_sat", out_bus(),
        {1'b1, 5'd2, 1'b1, 32'h42, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 2'd3});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
